// File: rtl/int_alu_pkg.sv
// Shared definitions for the integer arithmetic blocks.
// Holds the state encoding of the sequential divider FSM.
package int_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage : int_alu_pkg

// File: rtl/int_divider_seq.sv
// Sequential restoring integer divider, one quotient bit per clock.
// A start in IDLE or DONE latches the operands. A nonzero divisor runs WIDTH
// shift-subtract iterations in CALC, then writes the results on DONE entry.
// A zero divisor goes straight to DONE with quotient all-ones and
// remainder = dividend.
// Optional macro DIV_SIGNED_EN adds the signed_op port. The signs are
// stripped when the operands are accepted and restored on DONE entry, so
// signed and unsigned divisions take the same number of cycles.
module int_divider_seq
    import int_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;      // partial remainder, one guard bit
    logic [WIDTH-1:0] quo_q, quo_d;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0] dv_mag;

`ifdef DIV_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
    logic dd_neg, dv_neg;
`endif

    // Operand magnitudes presented to the array at acceptance time
    always_comb begin
`ifdef DIV_SIGNED_EN
        dd_neg = signed_op & dividend[WIDTH-1];
        dv_neg = signed_op & divisor[WIDTH-1];
        dd_mag = dd_neg ? (~dividend + ONE_W) : dividend;
        dv_mag = dv_neg ? (~divisor + ONE_W) : divisor;
`else
        dd_mag = dividend;
        dv_mag = divisor;
`endif
    end

    // Trial subtraction: bring down the next dividend bit and subtract the divisor
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {2'b00, dvs_q};

    // FSM and datapath next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            CALC: begin
                if (cnt_q == LAST_CNT) begin
                    // All bits resolved; publish results with signs restored
                    state_d = DONE;
                    dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
                    quotient_d  = neg_quo_q ? (~quo_q + ONE_W) : quo_q;
                    remainder_d = neg_rem_q ? (~rem_q[WIDTH-1:0] + ONE_W)
                                            : rem_q[WIDTH-1:0];
`else
                    quotient_d  = quo_q;
                    remainder_d = rem_q[WIDTH-1:0];
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (!diff[WIDTH+1]) begin
                        rem_d = diff[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: begin
                // IDLE and DONE both accept a new request
                if (start) begin
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = CALC;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = dd_mag;
                        dvs_d   = dv_mag;
`ifdef DIV_SIGNED_EN
                        neg_quo_d = dd_neg ^ dv_neg;
                        neg_rem_d = dd_neg;
`endif
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State registers; reset abandons any division in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule : int_divider_seq

// File: tb/tb_int_divider_seq.sv
// Testbench for int_divider_seq (WIDTH=8).
// Expected results go into a scoreboard queue when a request is driven. A
// monitor pops and checks an entry on every done pulse. The directed
// sequence checks latency, busy, holding of results and reset abort.
// Signed cases are included when DIV_SIGNED_EN is defined.
module tb_int_divider_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
`ifdef DIV_SIGNED_EN
    logic         signed_op;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t  sb[$];
    string tags[$];
    int    vectors     = 0;
    int    miscompares = 0;

    int_divider_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t  e;
        string t;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'h0);
            end else begin
                e = sb.pop_front();
                t = tags.pop_front();
                $display("txn %s: quotient=%0h remainder=%0h dbz=%0b (want %0h %0h %0b)",
                         t, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
                chk({t, "_quotient"},  32'(quotient),    32'(e.q));
                chk({t, "_remainder"}, 32'(remainder),   32'(e.r));
                chk({t, "_dbz"},       32'(div_by_zero), 32'(e.dbz));
            end
        end
    end

    // Drive one request and return #1 after the accepting edge
    task automatic start_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back('{q: eq, r: er, dbz: edbz});
        tags.push_back(tag);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges after the accepting edge until done is seen (bounded)
    task automatic wait_done(input string tag, input int k0, input int exp_lat, input logic exp_busy);
        int k;
        k = k0;
        @(negedge clk);
        while (done !== 1'b1 && k < 40) begin
            chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'h0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef DIV_SIGNED_EN
        signed_op = 1'b0;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_quotient", 32'(quotient), 32'h0);
        chk("rst_remainder", 32'(remainder), 32'h0);
        chk("rst_dbz", 32'(div_by_zero), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'h0);
        end

        // 100/7: the done pulse follows the ninth edge after acceptance
        start_div("u_100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        wait_done("u_100_7", 0, 9, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold_quotient", 32'(quotient), 32'd14);
        chk("hold_remainder", 32'(remainder), 32'd2);
        chk("hold_done_low", 32'(done), 32'h0);

        // Divide by zero: done at once, busy never rises
        start_div("u_5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
        wait_done("u_5_0", 0, 0, 1'b0);
        // The next nonzero-divisor result clears div_by_zero
        start_div("u_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        wait_done("u_255_1", 0, 9, 1'b1);
        start_div("u_7_200", 8'd7, 8'd200, 8'd0, 8'd7, 1'b0);
        wait_done("u_7_200", 0, 9, 1'b1);
        start_div("u_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        wait_done("u_255_255", 0, 9, 1'b1);

`ifdef DIV_SIGNED_EN
        signed_op = 1'b1;
        start_div("s_m100_7", 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0);
        wait_done("s_m100_7", 0, 9, 1'b1);
        start_div("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
        wait_done("s_m128_m1", 0, 9, 1'b1);
        start_div("s_100_m7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0);
        wait_done("s_100_m7", 0, 9, 1'b1);
        start_div("s_m7_0", 8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1);
        wait_done("s_m7_0", 0, 0, 1'b0);
        signed_op = 1'b0;
        start_div("u_156_7", 8'h9C, 8'h07, 8'd22, 8'd2, 1'b0);
        wait_done("u_156_7", 0, 9, 1'b1);
`endif

        // 200/3 with a 9/9 start pulse three cycles in, which must be ignored
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd200; divisor = 8'd3;
        sb.push_back('{q: 8'd66, r: 8'd2, dbz: 1'b0});
        tags.push_back("u_200_3_glitch");
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd9; divisor = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("u_200_3_glitch", 3, 9, 1'b1);
        repeat (12) @(negedge clk);
        chk("glitch_hold_quotient", 32'(quotient), 32'd66);

        // Reset during iteration 4 of 100/7: outputs clear immediately
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_quotient", 32'(quotient), 32'h0);
        chk("abort_remainder", 32'(remainder), 32'h0);
        chk("abort_dbz", 32'(div_by_zero), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'h0);
        end
        start_div("u_3_10", 8'd3, 8'd10, 8'd0, 8'd3, 1'b0);
        wait_done("u_3_10", 0, 9, 1'b1);

        // Back-to-back: start held high, second request accepted in DONE
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd50; divisor = 8'd6;
        sb.push_back('{q: 8'd8, r: 8'd2, dbz: 1'b0});
        tags.push_back("b2b_50_6");
        @(posedge clk); #1;
        dividend = 8'd77; divisor = 8'd5;
        sb.push_back('{q: 8'd15, r: 8'd2, dbz: 1'b0});
        tags.push_back("b2b_77_5");
        wait_done("b2b_50_6", 0, 9, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("b2b_77_5", 0, 9, 1'b1);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_int_divider_seq

// File: doc/int_divider_seq.md
INT_DIVIDER_SEQ -- requirements
Module: int_divider_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 4..32).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled on clk.
REQ-005 SHALL have port dividend  input  WIDTH  dividend, sampled only when start is accepted.
REQ-006 SHALL have port divisor  input  WIDTH  divisor, sampled only when start is accepted.
REQ-007 SHALL have port signed_op  input  1  1 = two's-complement operands (present only with DIV_SIGNED_EN).
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking valid results.
REQ-010 SHALL have port quotient  output  WIDTH  quotient result.
REQ-011 SHALL have port remainder  output  WIDTH  remainder result.
REQ-012 SHALL have port div_by_zero  output  1  high with results when divisor was zero.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC on accepted start with nonzero divisor; IDLE->DONE on accepted start with zero divisor; CALC->DONE after WIDTH iterations; DONE->IDLE otherwise.
REQ-014 SHALL accept start only when busy==0 (IDLE or DONE); start in DONE goes directly to CALC/DONE as in IDLE.
REQ-015 SHALL ignore start while busy==1; latched operands unaffected.
REQ-016 SHALL perform one restoring shift-subtract iteration per cycle in CALC, on a WIDTH+1-bit partial remainder, MSB first.
REQ-017 SHALL assert busy exactly in CALC; nonzero-divisor latency: done high in the cycle after WIDTH+1 rising edges counted from the accepting edge.
REQ-018 SHALL, for zero divisor, assert done one cycle after acceptance with quotient all-ones, remainder = dividend, div_by_zero=1, busy never high.
REQ-019 SHALL hold quotient, remainder, div_by_zero stable from done until the next accepted start updates them at DONE entry.
REQ-020 SHALL clear div_by_zero at the next result with nonzero divisor.
REQ-021 SHALL produce quotient = floor(dividend/divisor), remainder = dividend mod divisor for unsigned operation.

Reset
REQ-022 SHALL, on rst_n low (any cycle, including mid-CALC), abort work, enter IDLE, and drive busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-023 SHALL not assert done in the cycle after reset release unless a start was accepted.

Configuration
REQ-024 SHALL support macro DIV_SIGNED_EN; when defined, signed_op exists and signed_op=1 yields quotient truncated toward zero and remainder carrying the dividend's sign.
REQ-025 SHALL, with DIV_SIGNED_EN, map most-negative/-1 to quotient = most-negative, remainder = 0, div_by_zero=0; zero-divisor rule of REQ-018 unchanged.
REQ-026 SHALL, without DIV_SIGNED_EN, omit signed_op and all sign-correction logic; operation is unsigned only, latency identical.
REQ-027 SHALL keep latency independent of signed_op (sign conversion folded into acceptance and DONE-entry cycles).

Structure
REQ-028 SHALL place the FSM state typedef (IDLE/CALC/DONE) in shared package int_alu_pkg.
REQ-029 SHALL use an iteration counter of $clog2(WIDTH+1) bits declared locally.
REQ-030 SHALL be a single module; no sub-module.

Verification (WIDTH=8)
REQ-031 SHALL cover 100/7 unsigned -> quotient 14, remainder 2, div_by_zero 0, done 9 edges after accept.
REQ-032 SHALL cover 5/0 -> quotient 0xFF, remainder 5, div_by_zero 1, done 1 cycle after accept, busy never high.
REQ-033 SHALL cover signed -100/7 and -128/-1 -> quotient 0xF2 remainder 0xFE; quotient 0x80 remainder 0x00.
REQ-034 SHALL cover 200/3 then start pulse with 9/9 at cycle 3 -> second start ignored, results 66/2.
REQ-035 SHALL cover rst_n low at CALC iteration 4 of 100/7 -> all outputs zero immediately, no done; subsequent 3/10 -> quotient 0, remainder 3.
REQ-036 SHALL cover back-to-back: start held high through DONE -> second division accepted in DONE, results updated at its DONE.
